// File: rtl/fmm_reduce_barrett_stage.sv
// Four-stage Barrett reduction of a 2K-bit product modulo a runtime-loaded K-bit q.
// Optional input range checking (range_err port) is enabled by FMM_REDUCE_RANGE_CHECK_EN.
module fmm_reduce_barrett_stage #(
  parameter int unsigned K          = 31,
  parameter int unsigned PROD_WIDTH = 63,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  cfg_we,
  input  logic [K-1:0]          cfg_q,
  input  logic [K:0]            cfg_mu,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K-1:0]          out_res,
  output logic [TAG_W-1:0]      out_tag,
`ifdef FMM_REDUCE_RANGE_CHECK_EN
  output logic                  range_err,
`endif
  output logic                  idle
);

  localparam int unsigned XW  = 2 * K;
  localparam int unsigned Q2W = 2 * K + 3;

  // mu carries one extra bit so the reset value 2^(K+1) is representable
  logic [K-1:0]     q_r;
  logic [K+1:0]     mu_r;

  logic             v1, v2, v3, v4;
  logic             en1, en2, en3, en4;
  logic [XW-1:0]    x1;
  logic [K:0]       xl2, q3_2, r3;
  logic [TAG_W-1:0] t1, t2, t3;

  logic [K:0]       q1_c, q3_c, r3_c, c1_c, c2_c, qx_c;
  logic [Q2W-1:0]   q2_c;
  logic             cfg_ok_c;
  logic             unused_hi_c;

  assign unused_hi_c = ^in_prod[PROD_WIDTH-1:XW];

  // Each stage advances when empty or when the stage below advances (bubble collapse)
  assign en4      = ~v4 | out_ready;
  assign en3      = ~v3 | en4;
  assign en2      = ~v2 | en3;
  assign en1      = ~v1 | en2;
  assign in_ready = en1;
  assign out_valid = v4;
  assign idle     = ~(v1 | v2 | v3 | v4);

  assign qx_c = {1'b0, q_r};
  assign q1_c = x1[XW-1:K-1];
  assign q2_c = Q2W'(q1_c) * Q2W'(mu_r);
  assign q3_c = (K+1)'(q2_c >> (K + 1));
  assign r3_c = xl2 - q3_2 * qx_c;
  assign c1_c = (r3 >= qx_c) ? r3 - qx_c : r3;
  assign c2_c = (c1_c >= qx_c) ? c1_c - qx_c : c1_c;

  assign cfg_ok_c = cfg_we & idle & ~in_valid & cfg_q[K-1];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      q_r     <= {1'b1, {(K-1){1'b0}}};
      mu_r    <= {1'b1, {(K+1){1'b0}}};
      cfg_err <= 1'b0;
    end else if (cfg_ok_c) begin
      q_r  <= cfg_q;
      mu_r <= {1'b0, cfg_mu};
    end else if (cfg_we) begin
      cfg_err <= 1'b1;
    end
  end

  // Pipeline registers; data only loads when the upstream stage holds a valid item
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      v4      <= 1'b0;
      x1      <= '0;
      xl2     <= '0;
      q3_2    <= '0;
      r3      <= '0;
      t1      <= '0;
      t2      <= '0;
      t3      <= '0;
      out_res <= '0;
      out_tag <= '0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
        if (in_valid) begin
          x1 <= in_prod[XW-1:0];
          t1 <= in_tag;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          xl2  <= x1[K:0];
          q3_2 <= q3_c;
          t2   <= t1;
        end
      end
      if (en3) begin
        v3 <= v2;
        if (v2) begin
          r3 <= r3_c;
          t3 <= t2;
        end
      end
      if (en4) begin
        v4 <= v3;
        if (v3) begin
          out_res <= K'(c2_c);
          out_tag <= t3;
        end
      end
    end
  end

`ifdef FMM_REDUCE_RANGE_CHECK_EN
  // Sticky flag: high product bits at accept, or an oversized quotient estimate entering S3
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      range_err <= 1'b0;
    end else if ((in_valid & en1 & (|in_prod[PROD_WIDTH-1:XW])) |
                 (v2 & en3 & (q3_2 >= qx_c))) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fmm_reduce_barrett_stage.sv
// Scoreboard bench for fmm_reduce_barrett_stage; range_err checks only with FMM_REDUCE_RANGE_CHECK_EN.
module tb_fmm_reduce_barrett_stage;

  localparam int unsigned K  = 31;
  localparam int unsigned PW = 63;
  localparam int unsigned TW = 8;

  logic          ap_clk, ap_rst;
  logic          cfg_we;
  logic [K-1:0]  cfg_q;
  logic [K:0]    cfg_mu;
  logic          cfg_err;
  logic          in_valid, in_ready;
  logic [PW-1:0] in_prod;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [K-1:0]  out_res;
  logic [TW-1:0] out_tag;
  logic          idle;
`ifdef FMM_REDUCE_RANGE_CHECK_EN
  logic          range_err;
`endif

  fmm_reduce_barrett_stage #(.K(K), .PROD_WIDTH(PW), .TAG_W(TW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
`ifdef FMM_REDUCE_RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .idle(idle)
  );

  typedef struct packed {
    logic [K-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int run = 0;
  int max_run = 0;
  int first_out_cyc = 0;
  int last_acc_cyc = 0;
  int stalls = 0;
  bit seen_out = 0;
  bit hold_pending = 0;
  bit bp_en = 0;
  logic [K-1:0]  held_res;
  logic [TW-1:0] held_tag;
  longint unsigned cur_q;

  localparam longint unsigned MERSENNE = 64'd2147483647;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc++;

  always @(posedge ap_clk) begin
    if (bp_en) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard compare on transfer, stability check across stalls
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      hold_pending = 0;
      run = 0;
    end else if (out_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (!seen_out) begin
        seen_out = 1;
        first_out_cyc = cyc;
      end
      if (hold_pending) begin
        checks++;
        if (out_res !== held_res || out_tag !== held_tag) begin
          errors++;
          $display("FAIL hold_stable: res=%0d tag=%0d, required res=%0d tag=%0d",
                   out_res, out_tag, held_res, held_tag);
        end
      end
      if (out_ready) begin
        hold_pending = 0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: res=%0d tag=%0d, required no output", out_res, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_res !== e.res || out_tag !== e.tag) begin
            errors++;
            $display("FAIL result: res=%0d tag=%0d, required res=%0d tag=%0d",
                     out_res, out_tag, e.res, e.tag);
          end
        end
      end else begin
        hold_pending = 1;
        held_res = out_res;
        held_tag = out_tag;
      end
    end else begin
      run = 0;
      hold_pending = 0;
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    step();
    step();
    ap_rst = 1'b0;
    sb.delete();
    cur_q = 64'd1 << (K - 1);
  endtask

  function automatic logic [K:0] mu_of(input longint unsigned q);
    longint unsigned m;
    m = (64'd1 << (2 * K)) / q;
    return (K+1)'(m);
  endfunction

  task automatic load_cfg(input longint unsigned q, input bit expect_ok);
    cfg_q  = K'(q);
    cfg_mu = mu_of(q);
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    if (expect_ok) cur_q = q;
  endtask

  task automatic send(input longint unsigned x, input logic [TW-1:0] tag);
    exp_t e;
    longint unsigned xm;
    bit ok;
    xm = x & ((64'd1 << (2 * K)) - 1);
    e.res = K'(xm % cur_q);
    e.tag = tag;
    in_valid = 1'b1;
    in_prod  = PW'(x);
    in_tag   = tag;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge ap_clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b, required 1 within 200 cycles", in_ready);
    end else begin
      sb.push_back(e);
      last_acc_cyc = cyc;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_tag !== '0 || cfg_err !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: ov=%0b res=%0d tag=%0d err=%0b idle=%0b, required 0 0 0 0 1",
               out_valid, out_res, out_tag, cfg_err, idle);
    end
  endtask

  task automatic test_default_cfg();
    out_ready = 1'b1;
    send((64'd1 << 30) + 123, 8'd9);
    drain();
  endtask

  task automatic test_cfg_badq();
    do_reset();
    load_cfg(64'd1000, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_badq_err: cfg_err=%0b, required 1", cfg_err);
    end
    send((64'd1 << 30) + 5, 8'd10);
    drain();
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_sticky: cfg_err=%0b, required 1", cfg_err);
    end
    do_reset();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear: cfg_err=%0b, required 0", cfg_err);
    end
  endtask

  task automatic test_mersenne();
    longint unsigned xs[4];
    int acc0;
    xs[0] = 0;
    xs[1] = 64'd2147483647;
    xs[2] = 64'd10737418242;
    xs[3] = 64'd4611686009837453316;
    load_cfg(MERSENNE, 1);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ok_err: cfg_err=%0b, required 0", cfg_err);
    end
    out_ready = 1'b1;
    seen_out = 0;
    acc0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], TW'(i + 1));
      if (i == 0) acc0 = last_acc_cyc;
    end
    drain();
    checks++;
    if (!seen_out || (first_out_cyc - acc0) != 4) begin
      errors++;
      $display("FAIL latency: cycles=%0d seen=%0b, required 4", first_out_cyc - acc0, seen_out);
    end
  endtask

  task automatic test_back_pressure();
    longint unsigned a, b;
    bp_en = 1;
    for (int i = 0; i < 16; i++) begin
      a = longint'($urandom) % cur_q;
      b = longint'($urandom) % cur_q;
      send(a * b, TW'(8'h40 + i));
    end
    drain();
    bp_en = 0;
    step();
    out_ready = 1'b1;
  endtask

  task automatic test_cfg_busy();
    out_ready = 1'b0;
    send(64'd10737418242, 8'h81);
    send(64'd4611686009837453316, 8'h82);
    load_cfg(64'd2147483629, 0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_busy_err: cfg_err=%0b, required 1", cfg_err);
    end
    out_ready = 1'b1;
    send(64'd3000000000000000000, 8'h83);
    drain();
    do_reset();
  endtask

  task automatic test_back_to_back();
    longint unsigned a;
    load_cfg(64'd2147483629, 1);
    out_ready = 1'b1;
    stalls = 0;
    max_run = 0;
    for (int i = 0; i < 100; i++) begin
      a = longint'($urandom) % cur_q;
      send(a * (cur_q - 1 - longint'(i)), TW'(i));
    end
    drain();
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_in_ready: stalls=%0d, required 0", stalls);
    end
    checks++;
    if (max_run != 100) begin
      errors++;
      $display("FAIL b2b_out_run: run=%0d, required 100", max_run);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(64'd12345, 8'h11);
    send(64'd67890, 8'h12);
    send(64'd99999, 8'h13);
    step();
    step();
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_fill: out_valid=%0b, required 1", out_valid);
    end
    ap_rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: out_valid=%0b idle=%0b, required 0 1", out_valid, idle);
    end
    step();
    ap_rst = 1'b0;
    sb.delete();
    cur_q = 64'd1 << (K - 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (idle !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: idle=%0b out_valid=%0b, required 1 0", idle, out_valid);
    end
  endtask

`ifdef FMM_REDUCE_RANGE_CHECK_EN
  task automatic test_range();
    do_reset();
    load_cfg(MERSENNE, 1);
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_init: range_err=%0b, required 0", range_err);
    end
    out_ready = 1'b1;
    send((64'd1 << 62) + 5, 8'h55);
    drain();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_set: range_err=%0b, required 1", range_err);
    end
    do_reset();
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_clear: range_err=%0b, required 0", range_err);
    end
  endtask
`endif

  initial begin
    ap_rst    = 1'b1;
    cfg_we    = 1'b0;
    cfg_q     = '0;
    cfg_mu    = '0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    cur_q     = 64'd1 << (K - 1);
    step();
    step();
    test_reset();
    ap_rst = 1'b0;
    step();
    test_default_cfg();
    test_cfg_badq();
    test_mersenne();
    test_back_pressure();
    test_cfg_busy();
    test_back_to_back();
    test_reset_midstream();
`ifdef FMM_REDUCE_RANGE_CHECK_EN
    test_range();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
